// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller that arbitrates the next PC and drives the PC register.
// Define PC_SEQ_MISALIGN_EN to halt on misaligned redirect targets instead of forcing alignment.
module pc_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INSTR_BYTES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  stall,
  input  logic                  imem_ready,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_target,
  input  logic                  ex_redir_valid,
  input  logic [DATA_WIDTH-1:0] ex_redir_target,
  input  logic                  id_jump_valid,
  input  logic [DATA_WIDTH-1:0] id_jump_target,
  input  logic [DATA_WIDTH-1:0] pc_cur,
  output logic [DATA_WIDTH-1:0] pc_next,
  output logic                  pc_en,
  output logic                  imem_req,
  output logic                  flush,
  output logic                  halted,
  output logic                  misalign_fault
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e                state_q, state_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [1:0]            pend_lvl_q, pend_lvl_d;
  logic [DATA_WIDTH-1:0] pend_target_q, pend_target_d;

  logic [1:0]            live_lvl;
  logic [DATA_WIDTH-1:0] live_target;
  logic                  sel_redirect;
  logic [DATA_WIDTH-1:0] sel_target;
  logic                  sel_misalign;
  logic                  advance;

  // Live redirect priority: trap (3) > EX (2) > ID (1); level 0 means no live redirect.
  always_comb begin
    live_lvl    = 2'd0;
    live_target = id_jump_target;
    if (trap_valid) begin
      live_lvl    = 2'd3;
      live_target = trap_target;
    end else if (ex_redir_valid) begin
      live_lvl    = 2'd2;
      live_target = ex_redir_target;
    end else if (id_jump_valid) begin
      live_lvl    = 2'd1;
      live_target = id_jump_target;
    end
`ifndef PC_SEQ_MISALIGN_EN
    live_target[1:0] = 2'b00;
`endif
  end

  // The pending slot only beats a live redirect of strictly lower level.
  always_comb begin
    sel_redirect = 1'b1;
    sel_target   = live_target;
    if (pend_valid_q && (pend_lvl_q > live_lvl)) begin
      sel_target = pend_target_q;
    end else if (live_lvl == 2'd0) begin
      sel_redirect = 1'b0;
      sel_target   = pc_cur + DATA_WIDTH'(INSTR_BYTES);
    end
  end

`ifdef PC_SEQ_MISALIGN_EN
  assign sel_misalign = sel_redirect && (sel_target[1:0] != 2'b00);
`else
  assign sel_misalign = 1'b0;
`endif

  assign advance = ((state_q == ST_FETCH) && imem_ready && !stall && !halt_req) ||
                   ((state_q == ST_HALTED) && trap_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (halt_req) begin
          state_d = imem_ready ? ST_HALTED : ST_DRAIN;
        end else if (advance && sel_misalign) begin
          state_d = ST_HALTED;
        end
      end
      ST_DRAIN: begin
        if (imem_ready) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (trap_valid) begin
          state_d = sel_misalign ? ST_HALTED : ST_FETCH;
        end else if (start) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_next  = sel_target;
    pc_en    = advance && !sel_misalign;
    flush    = advance && sel_redirect;
    imem_req = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    halted   = (state_q == ST_HALTED);
    if (state_q == ST_IDLE) begin
      pc_next = RESET_VECTOR;
      pc_en   = start;
      flush   = 1'b0;
    end
  end

  // Redirects that cannot be taken yet are parked; a lower-level one never displaces a higher.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_lvl_d    = pend_lvl_q;
    pend_target_d = pend_target_q;
    if (advance) begin
      pend_valid_d = 1'b0;
    end else if (((state_q == ST_FETCH) || (state_q == ST_DRAIN)) && (live_lvl != 2'd0) &&
                 (!pend_valid_q || (live_lvl >= pend_lvl_q))) begin
      pend_valid_d  = 1'b1;
      pend_lvl_d    = live_lvl;
      pend_target_d = live_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_q  <= 1'b0;
      pend_lvl_q    <= 2'd0;
      pend_target_q <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_lvl_q    <= pend_lvl_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef PC_SEQ_MISALIGN_EN
  logic misalign_fault_q, misalign_fault_d;

  assign misalign_fault_d = advance && sel_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_fault_q <= 1'b0;
    end else begin
      misalign_fault_q <= misalign_fault_d;
    end
  end

  assign misalign_fault = misalign_fault_q;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer; the bench itself plays the PC register.
module tb_pc_sequencer;

   localparam int DW = 32;
   localparam logic [DW-1:0] RV = 32'h0;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_DRAIN = 2;
   localparam int M_HALT  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, halt_req, stall, imem_ready;
   logic          trap_valid, ex_redir_valid, id_jump_valid;
   logic [DW-1:0] trap_target, ex_redir_target, id_jump_target, pc_cur;
   logic [DW-1:0] pc_next;
   logic          pc_en, imem_req, flush, halted, misalign_fault;

   typedef struct {
      bit          en;
      bit          chkNxt;
      logic [DW-1:0] nxt;
      bit          fl;
      bit          req;
      bit          hlt;
      bit          flt;
   } exp_t;

   exp_t expQ[$];
   int   testsRun  = 0;
   int   failCount = 0;

   int            mMode;
   bit            mPendValid;
   int            mPendLvl;
   logic [DW-1:0] mPendTgt;
   logic [DW-1:0] mPc;
   bit            mFault;
   bit            rstLevel;

   pc_sequencer #(
      .DATA_WIDTH  (DW),
      .RESET_VECTOR(RV),
      .INSTR_BYTES (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .halt_req       (halt_req),
      .stall          (stall),
      .imem_ready     (imem_ready),
      .trap_valid     (trap_valid),
      .trap_target    (trap_target),
      .ex_redir_valid (ex_redir_valid),
      .ex_redir_target(ex_redir_target),
      .id_jump_valid  (id_jump_valid),
      .id_jump_target (id_jump_target),
      .pc_cur         (pc_cur),
      .pc_next        (pc_next),
      .pc_en          (pc_en),
      .imem_req       (imem_req),
      .flush          (flush),
      .halted         (halted),
      .misalign_fault (misalign_fault)
   );

   // Free-running clock; the bench drives on negedge and samples two time units later.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, advances the reference model and queues what the DUT must show.
   task automatic applyStimulus(input bit s, input bit h, input bit st, input bit rdy,
                                input bit tv, input logic [DW-1:0] tt,
                                input bit ev, input logic [DW-1:0] et,
                                input bit iv, input logic [DW-1:0] it);
      exp_t          e;
      int            liveLvl;
      logic [DW-1:0] liveTgt;
      int            candLvl[2];
      logic [DW-1:0] candTgt[2];
      int            bestLvl;
      logic [DW-1:0] bestTgt;
      bit            redir, mis, adv;

      @(negedge clk);
      rst = rstLevel;
      start = s; halt_req = h; stall = st; imem_ready = rdy;
      trap_valid = tv; trap_target = tt;
      ex_redir_valid = ev; ex_redir_target = et;
      id_jump_valid = iv; id_jump_target = it;
      pc_cur = mPc;

      e = '{en: 0, chkNxt: 0, nxt: '0, fl: 0, req: 0, hlt: 0, flt: 0};

      if (!rstLevel) begin
         mMode = M_IDLE; mPendValid = 0; mPendLvl = 0; mFault = 0;
         e.chkNxt = 1; e.nxt = RV;
         expQ.push_back(e);
         return;
      end

      e.flt  = mFault;
      mFault = 0;

      liveLvl = tv ? 3 : (ev ? 2 : (iv ? 1 : 0));
      liveTgt = tv ? tt : (ev ? et : it);
`ifndef PC_SEQ_MISALIGN_EN
      liveTgt = liveTgt & ~32'h3;
`endif

      // Older pending entry listed first, so ties resolve to the newer live redirect.
      candLvl[0] = mPendValid ? mPendLvl : 0;
      candTgt[0] = mPendTgt;
      candLvl[1] = liveLvl;
      candTgt[1] = liveTgt;
      bestLvl = 0;
      bestTgt = mPc + 32'd4;
      for (int i = 0; i < 2; i++) begin
         if (candLvl[i] > 0 && candLvl[i] >= bestLvl) begin
            bestLvl = candLvl[i];
            bestTgt = candTgt[i];
         end
      end
      redir = (bestLvl > 0);
      mis = 0;
`ifdef PC_SEQ_MISALIGN_EN
      mis = redir && (bestTgt[1:0] != 2'b00);
`endif

      adv = 0;
      case (mMode)
         M_IDLE: begin
            e.chkNxt = 1; e.nxt = RV;
            if (s) begin
               e.en = 1; mPc = RV; mMode = M_FETCH;
            end
         end
         M_FETCH: begin
            e.req = 1;
            if (h) begin
               parkLive(liveLvl, liveTgt);
               mMode = rdy ? M_HALT : M_DRAIN;
            end else if (rdy && !st) begin
               adv = 1;
            end else begin
               parkLive(liveLvl, liveTgt);
            end
         end
         M_DRAIN: begin
            e.req = 1;
            parkLive(liveLvl, liveTgt);
            if (rdy) mMode = M_HALT;
         end
         default: begin
            e.hlt = 1;
            if (tv) adv = 1;
            else if (s) mMode = M_FETCH;
         end
      endcase

      if (adv) begin
         mPendValid = 0;
         e.fl = redir;
         if (mis) begin
            mMode = M_HALT; mFault = 1;
         end else begin
            e.en = 1; e.chkNxt = 1; e.nxt = bestTgt; mPc = bestTgt; mMode = M_FETCH;
         end
      end
      expQ.push_back(e);
   endtask

   task automatic parkLive(input int lvl, input logic [DW-1:0] tgt);
      if (lvl > 0 && (!mPendValid || lvl >= mPendLvl)) begin
         mPendValid = 1; mPendLvl = lvl; mPendTgt = tgt;
      end
   endtask

   // Monitor: pops one expectation per cycle and compares it with what the DUT presents.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("pc_en", DW'(pc_en), DW'(e.en));
            checkOutput("flush", DW'(flush), DW'(e.fl));
            checkOutput("imem_req", DW'(imem_req), DW'(e.req));
            checkOutput("halted", DW'(halted), DW'(e.hlt));
            checkOutput("misalign_fault", DW'(misalign_fault), DW'(e.flt));
            if (e.chkNxt) checkOutput("pc_next", pc_next, e.nxt);
         end
      end
   end

   // Directed scenarios first, then a randomized run against the reference model.
   initial begin
      bit s, h, st, rdy, tv, ev, iv;
      rst = 1'b0; rstLevel = 0;
      start = 0; halt_req = 0; stall = 0; imem_ready = 0;
      trap_valid = 0; ex_redir_valid = 0; id_jump_valid = 0;
      trap_target = '0; ex_redir_target = '0; id_jump_target = '0;
      mMode = M_IDLE; mPendValid = 0; mPendLvl = 0; mPendTgt = '0; mPc = '0; mFault = 0;
      pc_cur = '0;

      applyStimulus(0,0,0,0, 0,0, 0,0, 0,0);
      applyStimulus(0,0,0,0, 0,0, 0,0, 0,0);
      rstLevel = 1;
      applyStimulus(0,0,0,1, 1,32'h40, 1,32'h44, 0,0);

      // Start and sequential fetch: 0x0, 0x4, 0x8, 0xC.
      applyStimulus(1,0,0,1, 0,0, 0,0, 0,0);
      repeat (3) applyStimulus(0,0,0,1, 0,0, 0,0, 0,0);

      // EX redirect held across a three-cycle stall.
      mPc = 32'h10;
      repeat (3) applyStimulus(0,0,1,1, 0,0, 1,32'h100, 0,0);
      applyStimulus(0,0,0,1, 0,0, 0,0, 0,0);

      // All three redirects at once, then pending EX outranks a later live ID jump.
      applyStimulus(0,0,0,1, 1,32'h80, 1,32'h200, 1,32'h300);
      applyStimulus(0,0,1,1, 0,0, 1,32'h200, 0,0);
      applyStimulus(0,0,1,1, 0,0, 0,0, 1,32'h300);
      applyStimulus(0,0,0,1, 0,0, 0,0, 0,0);

      // Sequential wrap at the top of the address space.
      mPc = 32'hFFFF_FFFC;
      applyStimulus(0,0,0,1, 0,0, 0,0, 0,0);

      // Halt with memory busy: drain, halt, resume at pc_cur + 4.
      applyStimulus(0,1,0,0, 0,0, 0,0, 0,0);
      applyStimulus(0,0,0,0, 0,0, 0,0, 0,0);
      applyStimulus(0,0,0,1, 0,0, 0,0, 0,0);
      applyStimulus(0,0,0,0, 0,0, 0,0, 0,0);
      applyStimulus(1,0,0,0, 0,0, 0,0, 0,0);
      applyStimulus(0,0,0,1, 0,0, 0,0, 0,0);

      // Halt with memory ready, stall dominated by halt, then a trap wakes the front end.
      applyStimulus(0,1,1,1, 0,0, 0,0, 0,0);
      applyStimulus(0,0,0,0, 1,32'h80, 0,0, 0,0);
      applyStimulus(0,0,0,1, 0,0, 0,0, 0,0);

      // Misaligned EX target.
      applyStimulus(0,0,0,1, 0,0, 1,32'h102, 0,0);
      applyStimulus(0,0,0,1, 0,0, 0,0, 0,0);
      applyStimulus(1,0,0,1, 0,0, 0,0, 0,0);

      for (int n = 0; n < 600; n++) begin
         s   = ($urandom % 16) == 0;
         h   = ($urandom % 24) == 0;
         st  = ($urandom % 4) == 0;
         rdy = ($urandom % 4) != 0;
         tv  = ($urandom % 16) == 0;
         ev  = ($urandom % 6) == 0;
         iv  = ($urandom % 5) == 0;
         if (mMode == M_HALT && mPendValid) tv = 0;
         applyStimulus(s, h, st, rdy, tv, $urandom, ev, $urandom, iv, $urandom);
      end

      @(negedge clk);
      #4;
      testsRun++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
